// File: rtl/mult16_product_accumulator.sv
// ============================================================================
// mult16_product_accumulator
// ----------------------------------------------------------------------------
// Streaming multiply-accumulate back end for the combinational 16x16
// multiplier. It takes one unsigned product term per cycle and sums a group
// of terms (a dot product) into a wide accumulator. A group ends when a term
// tagged "last" is accepted. The finished sum is then held on a valid/ready
// result handshake until the consumer takes it.
//
// Optional feature (compile-time macro): SATURATE_ACC_EN
//   defined   : on carry-out the sum clamps to all-ones for the rest of the group
//   undefined : the sum wraps modulo 2^ACC_W
//   acc_ovf is a sticky overflow flag in both builds. The port list is the
//   same in both builds.
//
// Ports
//   clk        in   1       single clock, rising edge
//   rst        in   1       asynchronous active-high reset
//   product    in   PROD_W  unsigned product term
//   prod_valid in   1       product term valid
//   prod_last  in   1       term is the final one of the current group
//   prod_ready out  1       a term is accepted this cycle if prod_valid is high
//   acc_clear  in   1       synchronous abort/clear of the current group
//   acc_data   out  ACC_W   accumulated sum
//   acc_count  out  CNT_W   number of terms in acc_data (saturating)
//   acc_ovf    out  1       sticky overflow flag for the current group
//   acc_valid  out  1       acc_data holds a finished group
//   acc_ready  in   1       consumer takes the result
// ============================================================================
module mult16_product_accumulator #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] product,
    input  logic              prod_valid,
    input  logic              prod_last,
    output logic              prod_ready,
    input  logic              acc_clear,
    output logic [ACC_W-1:0]  acc_data,
    output logic [CNT_W-1:0]  acc_count,
    output logic              acc_ovf,
    output logic              acc_valid,
    input  logic              acc_ready
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q,   acc_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               ovf_q,   ovf_d;

    // One extra bit on the adder exposes the carry out of ACC_W.
    logic [ACC_W:0]     sum_s;
    logic               carry_s;
    logic [ACC_W-1:0]   acc_next_s;
    logic               take_s;

    // Ready is gated by rst so no term slips in while reset is asserted.
    assign prod_ready = (state_q == ACCUM) && !acc_clear && !rst;
    assign take_s     = prod_valid && prod_ready;

    assign acc_data   = acc_q;
    assign acc_count  = cnt_q;
    assign acc_ovf    = ovf_q;
    assign acc_valid  = (state_q == HOLD);

    // Adder with overflow handling (wrap or clamp depending on the build).
    always_comb begin
        sum_s   = {1'b0, acc_q} + (ACC_W+1)'(product);
        carry_s = sum_s[ACC_W];
`ifdef SATURATE_ACC_EN
        // Once clamped, stay clamped until the group is consumed or cleared.
        if (carry_s || ovf_q) begin
            acc_next_s = {ACC_W{1'b1}};
        end else begin
            acc_next_s = sum_s[ACC_W-1:0];
        end
`else
        acc_next_s = sum_s[ACC_W-1:0];
`endif
    end

    // Next-state and datapath update; acc_clear overrides everything else.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (acc_clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (take_s) begin
                        acc_d = acc_next_s;
                        ovf_d = ovf_q | carry_s;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end else begin
                            cnt_d = cnt_q;
                        end
                        if (prod_last) begin
                            state_d = HOLD;
                        end else begin
                            state_d = ACCUM;
                        end
                    end else begin
                        state_d = ACCUM;
                    end
                end
                HOLD: begin
                    if (acc_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    // State and accumulator registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mult16_product_accumulator.sv
// Testbench for mult16_product_accumulator (ACC_W = 34 so the overflow
// vectors are short). Results are checked through a scoreboard queue that a
// monitor drains on every result handshake; timing and reset behaviour are
// checked directly.
module tb_mult16_product_accumulator;

    localparam int PROD_W = 32;
    localparam int ACC_W  = 34;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst;
    logic [PROD_W-1:0] product;
    logic              prod_valid;
    logic              prod_last;
    logic              prod_ready;
    logic              acc_clear;
    logic [ACC_W-1:0]  acc_data;
    logic [CNT_W-1:0]  acc_count;
    logic              acc_ovf;
    logic              acc_valid;
    logic              acc_ready;

    typedef struct packed {
        logic [ACC_W-1:0] d;
        logic [CNT_W-1:0] c;
        logic             o;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    mult16_product_accumulator #(
        .PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .product   (product),
        .prod_valid(prod_valid),
        .prod_last (prod_last),
        .prod_ready(prod_ready),
        .acc_clear (acc_clear),
        .acc_data  (acc_data),
        .acc_count (acc_count),
        .acc_ovf   (acc_ovf),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [ACC_W-1:0] d, input logic [CNT_W-1:0] c, input logic o);
        exp_t e;
        e.d = d; e.c = c; e.o = o;
        exp_q.push_back(e);
    endtask

    // Present one term and hold it until accepted (bounded wait).
    task automatic send(input logic [PROD_W-1:0] p, input logic last);
        int n;
        product    = p;
        prod_last  = last;
        prod_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!prod_ready && n < 50);
        if (!prod_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: prod_ready stayed 0 for term 0x%0h", p);
        end
        @(posedge clk);
        #1;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
    endtask

    task automatic take_result();
        acc_ready = 1'b1;
        @(posedge clk);
        #1;
        acc_ready = 1'b0;
    endtask

    // Scoreboard monitor: every result handshake pops one expected entry.
    always @(negedge clk) begin
        if (!rst && acc_valid && acc_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: result 0x%0h with empty scoreboard", acc_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_data",  64'(acc_data),  64'(e.d));
                chk("sb_count", 64'(acc_count), 64'(e.c));
                chk("sb_ovf",   64'(acc_ovf),   64'(e.o));
            end
        end
    end

    initial begin
        logic [ACC_W-1:0] ovf_exp;
        rst = 1'b1; product = '0; prod_valid = 1'b1; prod_last = 1'b0;
        acc_clear = 1'b0; acc_ready = 1'b0;

        // 1: reset state with prod_valid asserted
        product = 32'd123;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data",  64'(acc_data),   64'd0);
        chk("rst_count", 64'(acc_count),  64'd0);
        chk("rst_valid", 64'(acc_valid),  64'd0);
        chk("rst_ovf",   64'(acc_ovf),    64'd0);
        chk("rst_ready", 64'(prod_ready), 64'd0);
        prod_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", 64'(prod_ready), 64'd1);
        @(posedge clk); #1;

        // 2: group 10,20,30 then hold the result for 5 cycles
        send(32'd10, 1'b0);
        send(32'd20, 1'b0);
        send(32'd30, 1'b1);
        chk("g_valid", 64'(acc_valid), 64'd1);
        chk("g_data",  64'(acc_data),  64'd60);
        chk("g_count", 64'(acc_count), 64'd3);
        prod_valid = 1'b1; product = 32'd99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_data",  64'(acc_data),   64'd60);
            chk("hold_count", 64'(acc_count),  64'd3);
            chk("hold_valid", 64'(acc_valid),  64'd1);
            chk("hold_ready", 64'(prod_ready), 64'd0);
        end
        prod_valid = 1'b0;
        push_exp(34'd60, 8'd3, 1'b0);
        take_result();
        chk("post_take_valid", 64'(acc_valid), 64'd0);
        chk("post_take_data",  64'(acc_data),  64'd0);

        // 3: five 0xFFFFFFFF terms overflow a 34-bit accumulator
        for (int i = 0; i < 5; i++) send(32'hFFFF_FFFF, (i == 4) ? 1'b1 : 1'b0);
`ifdef SATURATE_ACC_EN
        ovf_exp = 34'h3_FFFF_FFFF;
`else
        ovf_exp = 34'h0_FFFF_FFFB;
`endif
        chk("ovf_data", 64'(acc_data), 64'(ovf_exp));
        chk("ovf_flag", 64'(acc_ovf),  64'd1);
        push_exp(ovf_exp, 8'd5, 1'b1);
        take_result();

        // 4: abort a partial group with acc_clear, then a one-term group
        send(32'd5, 1'b0);
        send(32'd7, 1'b0);
        chk("pre_clr_data", 64'(acc_data), 64'd12);
        acc_clear = 1'b1; prod_valid = 1'b1; product = 32'd100;
        @(negedge clk);
        chk("clr_ready", 64'(prod_ready), 64'd0);
        @(posedge clk); #1;
        acc_clear = 1'b0; prod_valid = 1'b0;
        chk("clr_data",  64'(acc_data),  64'd0);
        chk("clr_count", 64'(acc_count), 64'd0);
        send(32'd9, 1'b1);
        chk("clr9_data",  64'(acc_data),  64'd9);
        chk("clr9_count", 64'(acc_count), 64'd1);
        push_exp(34'd9, 8'd1, 1'b0);
        take_result();

        // 5: single-term groups streamed with acc_ready tied high
        push_exp(34'd1, 8'd1, 1'b0);
        push_exp(34'd2, 8'd1, 1'b0);
        push_exp(34'd3, 8'd1, 1'b0);
        acc_ready = 1'b1;
        prod_valid = 1'b1; prod_last = 1'b1; product = 32'd1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("stream_ready", 64'(prod_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
            @(posedge clk); #1;
            if (i % 2 == 0) product = product + 32'd1;
            if (i == 4) begin
                prod_valid = 1'b0;
                prod_last  = 1'b0;
            end
        end
        acc_ready = 1'b0;
        chk("stream_drained", 64'(exp_q.size()), 64'd0);

        // 6: asynchronous reset while holding a result
        send(32'd10, 1'b0);
        send(32'd20, 1'b0);
        send(32'd30, 1'b1);
        chk("ar_pre_data", 64'(acc_data), 64'd60);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", 64'(acc_valid), 64'd0);
        chk("ar_data",  64'(acc_data),  64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
